// File: rtl/ecc_rd_scrub.sv
// Read-side post-correction stage: registers corrected words toward the consumer,
// counts correctable/uncorrectable errors, logs the first error and requests scrub writes.
module ecc_rd_scrub #(
    parameter int WDTH = 34,
    parameter int AWDT = 10,
    parameter int CWDT = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_rd_vld,
    output logic            o_rd_rdy,
    input  logic [AWDT-1:0] i_rd_addr,
    input  logic [WDTH-1:0] i_data,
    input  logic            i_err_detect,
    input  logic            i_err_multpl,
    output logic            o_vld,
    input  logic            i_rdy,
    output logic [WDTH-1:0] o_data,
    output logic            o_cerr,
    output logic            o_uerr,
    output logic            o_scrub_req,
    output logic [AWDT-1:0] o_scrub_addr,
    output logic [WDTH-1:0] o_scrub_data,
    input  logic            i_scrub_ack,
    input  logic            i_clr,
    output logic [CWDT-1:0] o_cerr_cnt,
    output logic [CWDT-1:0] o_uerr_cnt,
    output logic            o_scrub_drop,
    output logic            o_first_vld,
    output logic [AWDT-1:0] o_first_addr,
    output logic            o_first_uerr
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t          r_state;
    state_t          w_next;
    logic            w_accept;
    logic            w_acc_ce;
    logic            w_acc_ue;
    logic            w_load;
    logic            w_drop;
    logic            r_vld;
    logic [WDTH-1:0] r_data;
    logic            r_cerr;
    logic            r_uerr;
    logic [AWDT-1:0] r_scrub_addr;
    logic [WDTH-1:0] r_scrub_data;
    logic [CWDT-1:0] r_cerr_cnt;
    logic [CWDT-1:0] r_uerr_cnt;
    logic            r_drop;
    logic            r_first_vld;
    logic [AWDT-1:0] r_first_addr;
    logic            r_first_uerr;

    assign o_rd_rdy = ~r_vld | i_rdy;
    assign w_accept = i_rd_vld & o_rd_rdy;
    assign w_acc_ce = w_accept & i_err_detect & ~i_err_multpl;
    assign w_acc_ue = w_accept & i_err_detect & i_err_multpl;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_cerr <= 1'b0;
            r_uerr <= 1'b0;
        end else if (w_accept) begin
            r_vld  <= 1'b1;
            r_data <= i_data;
            r_cerr <= i_err_detect & ~i_err_multpl;
            r_uerr <= i_err_detect & i_err_multpl;
        end else if (i_rdy) begin
            r_vld <= 1'b0;
        end
    end

    // A clear coincident with an event leaves that event counted, not lost.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cerr_cnt <= '0;
            r_uerr_cnt <= '0;
        end else if (i_clr) begin
            r_cerr_cnt <= {{(CWDT-1){1'b0}}, w_acc_ce};
            r_uerr_cnt <= {{(CWDT-1){1'b0}}, w_acc_ue};
        end else begin
            if (w_acc_ce && r_cerr_cnt != {CWDT{1'b1}}) r_cerr_cnt <= r_cerr_cnt + 1'b1;
            if (w_acc_ue && r_uerr_cnt != {CWDT{1'b1}}) r_uerr_cnt <= r_uerr_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_first_uerr <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            if ((w_acc_ce || w_acc_ue) && (!r_first_vld || i_clr)) begin
                r_first_vld  <= 1'b1;
                r_first_addr <= i_rd_addr;
                r_first_uerr <= w_acc_ue;
            end else if (i_clr) begin
                r_first_vld <= 1'b0;
            end
            if (i_clr) r_drop <= w_drop;
            else if (w_drop) r_drop <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_scrub_addr <= '0;
            r_scrub_data <= '0;
        end else begin
            r_state <= w_next;
            if (w_load) begin
                r_scrub_addr <= i_rd_addr;
                r_scrub_data <= i_data;
            end
        end
    end

    // A new correctable word replaces the pending scrub only when the arbiter takes the old one.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_acc_ce) begin
                    w_load = 1'b1;
                    w_next = S_REQ;
                end
            end
            S_REQ: begin
                if (i_scrub_ack) begin
                    if (w_acc_ce) w_load = 1'b1;
                    else          w_next = S_IDLE;
                end else if (w_acc_ce) begin
                    w_drop = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_vld        = r_vld;
    assign o_data       = r_data;
    assign o_cerr       = r_cerr;
    assign o_uerr       = r_uerr;
    assign o_scrub_req  = (r_state == S_REQ);
    assign o_scrub_addr = r_scrub_addr;
    assign o_scrub_data = r_scrub_data;
    assign o_cerr_cnt   = r_cerr_cnt;
    assign o_uerr_cnt   = r_uerr_cnt;
    assign o_scrub_drop = r_drop;
    assign o_first_vld  = r_first_vld;
    assign o_first_addr = r_first_addr;
    assign o_first_uerr = r_first_uerr;

endmodule

// File: tb/tb_ecc_rd_scrub.sv
// Bench for ecc_rd_scrub: vector table for counters/log/scrub, queue scoreboard for the data path.
module tb_ecc_rd_scrub;

    localparam int WDTH = 34;
    localparam int AWDT = 10;
    localparam int CWDT = 4;

    typedef struct {
        logic            vld;
        logic [AWDT-1:0] addr;
        logic [WDTH-1:0] data;
        logic            det;
        logic            mul;
        logic            ack;
        logic            clr;
        logic [CWDT-1:0] eCnt;
        logic [CWDT-1:0] eUcnt;
        logic            eReq;
        logic [AWDT-1:0] eSaddr;
        logic [WDTH-1:0] eSdata;
        logic            eFvld;
        logic [AWDT-1:0] eFaddr;
        logic            eFuerr;
        logic            eDrop;
    } vec_t;

    typedef struct {
        logic [WDTH-1:0] data;
        logic            ce;
        logic            ue;
    } word_t;

    logic            clk;
    logic            rst;
    logic            rdVld;
    logic            rdRdy;
    logic [AWDT-1:0] rdAddr;
    logic [WDTH-1:0] dataIn;
    logic            errDet;
    logic            errMul;
    logic            oVld;
    logic            rdy;
    logic [WDTH-1:0] oData;
    logic            oCerr;
    logic            oUerr;
    logic            scrubReq;
    logic [AWDT-1:0] scrubAddr;
    logic [WDTH-1:0] scrubData;
    logic            scrubAck;
    logic            clr;
    logic [CWDT-1:0] cerrCnt;
    logic [CWDT-1:0] uerrCnt;
    logic            scrubDrop;
    logic            firstVld;
    logic [AWDT-1:0] firstAddr;
    logic            firstUerr;

    int    checks = 0;
    int    fails  = 0;
    word_t sb[$];
    vec_t  vecs[$];

    ecc_rd_scrub #(.WDTH(WDTH), .AWDT(AWDT), .CWDT(CWDT)) dut (
        .i_clk(clk), .i_rst(rst), .i_rd_vld(rdVld), .o_rd_rdy(rdRdy),
        .i_rd_addr(rdAddr), .i_data(dataIn), .i_err_detect(errDet), .i_err_multpl(errMul),
        .o_vld(oVld), .i_rdy(rdy), .o_data(oData), .o_cerr(oCerr), .o_uerr(oUerr),
        .o_scrub_req(scrubReq), .o_scrub_addr(scrubAddr), .o_scrub_data(scrubData),
        .i_scrub_ack(scrubAck), .i_clr(clr), .o_cerr_cnt(cerrCnt), .o_uerr_cnt(uerrCnt),
        .o_scrub_drop(scrubDrop), .o_first_vld(firstVld), .o_first_addr(firstAddr),
        .o_first_uerr(firstUerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Handshakes are judged at the falling edge, where inputs are already stable for the next rise.
    always @(negedge clk) begin
        if (!rst) begin
            if (oVld && rdy) begin
                if (sb.size() == 0) begin
                    check("sb_unexpected_word", 64'(oData), 64'hDEAD);
                end else begin
                    word_t w;
                    w = sb.pop_front();
                    check("sb_data", 64'(oData), 64'(w.data));
                    check("sb_cerr", 64'(oCerr), 64'(w.ce));
                    check("sb_uerr", 64'(oUerr), 64'(w.ue));
                end
            end
            if (rdVld && rdRdy) begin
                word_t n;
                n.data = dataIn;
                n.ce   = errDet & ~errMul;
                n.ue   = errDet & errMul;
                sb.push_back(n);
            end
        end
    end

    always @(posedge rst) sb.delete();

    function automatic vec_t mk(input logic v, input logic [AWDT-1:0] a, input logic [WDTH-1:0] d,
                                input logic det, input logic mul, input logic ack, input logic c,
                                input logic [CWDT-1:0] eC, input logic [CWDT-1:0] eU, input logic eR,
                                input logic [AWDT-1:0] eSa, input logic [WDTH-1:0] eSd,
                                input logic eFv, input logic [AWDT-1:0] eFa, input logic eFu,
                                input logic eD);
        vec_t r;
        r.vld = v; r.addr = a; r.data = d; r.det = det; r.mul = mul; r.ack = ack; r.clr = c;
        r.eCnt = eC; r.eUcnt = eU; r.eReq = eR; r.eSaddr = eSa; r.eSdata = eSd;
        r.eFvld = eFv; r.eFaddr = eFa; r.eFuerr = eFu; r.eDrop = eD;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [AWDT-1:0] a, input logic [WDTH-1:0] d,
                         input logic det, input logic mul, input logic r, input logic ack,
                         input logic c);
        rdVld = v; rdAddr = a; dataIn = d; errDet = det; errMul = mul;
        rdy = r; scrubAck = ack; clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.vld, v.addr, v.data, v.det, v.mul, 1'b1, v.ack, v.clr);
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        string t;
        t = $sformatf("vec%0d", idx);
        check({t, "_cerr_cnt"}, 64'(cerrCnt), 64'(v.eCnt));
        check({t, "_uerr_cnt"}, 64'(uerrCnt), 64'(v.eUcnt));
        check({t, "_scrub_req"}, 64'(scrubReq), 64'(v.eReq));
        if (v.eReq) begin
            check({t, "_scrub_addr"}, 64'(scrubAddr), 64'(v.eSaddr));
            check({t, "_scrub_data"}, 64'(scrubData), 64'(v.eSdata));
        end
        check({t, "_first_vld"}, 64'(firstVld), 64'(v.eFvld));
        if (v.eFvld) begin
            check({t, "_first_addr"}, 64'(firstAddr), 64'(v.eFaddr));
            check({t, "_first_uerr"}, 64'(firstUerr), 64'(v.eFuerr));
        end
        check({t, "_scrub_drop"}, 64'(scrubDrop), 64'(v.eDrop));
    endtask

    initial begin
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(1, AWDT'(i), 34'h2_A000_0000 + 34'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 'h3A, 'h155, 1, 0, 0, 0, 1, 0, 1, 'h3A, 'h155, 1, 'h3A, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h3A, 'h155, 1, 'h3A, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h3A, 'h155, 1, 'h3A, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, 'h3A, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 'h10, 'h210, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 'h10, 1, 0));
        vecs.push_back(mk(1, 'h11, 'h211, 1, 0, 0, 0, 1, 1, 1, 'h11, 'h211, 1, 'h10, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 1, 'h10, 1, 0));
        vecs.push_back(mk(1, 'h12, 'h212, 0, 1, 0, 0, 1, 1, 0, 0, 0, 1, 'h10, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 'h20, 'h320, 1, 0, 0, 0, 1, 0, 1, 'h20, 'h320, 1, 'h20, 0, 0));
        vecs.push_back(mk(1, 'h21, 'h321, 1, 0, 0, 0, 2, 0, 1, 'h20, 'h320, 1, 'h20, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 'h20, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 'h20, 'h320, 1, 0, 0, 0, 1, 0, 1, 'h20, 'h320, 1, 'h20, 0, 0));
        vecs.push_back(mk(1, 'h21, 'h321, 1, 0, 1, 0, 2, 0, 1, 'h21, 'h321, 1, 'h20, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 1, 'h20, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        rst = 1'b1; rdVld = 0; rdAddr = '0; dataIn = '0; errDet = 0; errMul = 0;
        rdy = 1; scrubAck = 0; clr = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_o_vld", 64'(oVld), 0);
        check("reset_o_data", 64'(oData), 0);
        check("reset_scrub_req", 64'(scrubReq), 0);
        check("reset_cerr_cnt", 64'(cerrCnt), 0);
        check("reset_first_vld", 64'(firstVld), 0);
        check("reset_first_addr", 64'(firstAddr), 0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Backpressure: the held word must survive while the consumer stalls.
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(1, 'h40, 'hAAA, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            drive(1, 'h41, 'hBBB, 0, 0, 0, 0, 0);
            check("bp_rd_rdy", 64'(rdRdy), 0);
            check("bp_data_held", 64'(oData), 'hAAA);
        end
        drive(1, 'h41, 'hBBB, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        check("bp_sb_empty", 64'(sb.size()), 0);

        drive(0, 0, 0, 0, 0, 1, 1, 1);
        for (int k = 0; k < 20; k++)
            drive(1, AWDT'(k + 'h100), 34'(k), 1, 0, 1, 1, 0);
        check("sat_cerr_cnt", 64'(cerrCnt), 15);
        drive(1, 'h155, 'h999, 1, 0, 1, 1, 1);
        check("clr_coinc_cerr_cnt", 64'(cerrCnt), 1);
        check("clr_coinc_uerr_cnt", 64'(uerrCnt), 0);
        check("clr_coinc_first_vld", 64'(firstVld), 1);
        check("clr_coinc_first_addr", 64'(firstAddr), 'h155);
        drive(0, 0, 0, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0, 0);

        // Reset lands mid-cycle with a scrub pending and a word stalled at the output.
        drive(1, 'h2A, 'h77, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("prerst_scrub_req", 64'(scrubReq), 1);
        check("prerst_o_vld", 64'(oVld), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_o_vld", 64'(oVld), 0);
        check("rst_o_data", 64'(oData), 0);
        check("rst_scrub_req", 64'(scrubReq), 0);
        check("rst_scrub_addr", 64'(scrubAddr), 0);
        check("rst_scrub_data", 64'(scrubData), 0);
        check("rst_cerr_cnt", 64'(cerrCnt), 0);
        check("rst_first_vld", 64'(firstVld), 0);
        check("rst_first_addr", 64'(firstAddr), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 0);
            check("postrst_scrub_req", 64'(scrubReq), 0);
            check("postrst_o_vld", 64'(oVld), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
